// File: rtl/adsr_envelope_if.sv
// Valid/ready sample stream between tone generator, envelope stage and mixer.
// The master drives valid/data, the slave answers with ready.
interface adsr_envelope_if #(
    parameter int unsigned width_p = 12
) ();
    logic               valid;
    logic               ready;
    logic [width_p-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: scales each accepted sample by the current level and
// advances the level one step per accepted sample, gated by a level-sensitive note gate.
module adsr_envelope #(
    parameter int unsigned width_p         = 12,
    parameter int unsigned env_width_p     = 8,
    parameter int unsigned attack_step_p   = 64,
    parameter int unsigned decay_step_p    = 16,
    parameter int unsigned sustain_level_p = 128,
    parameter int unsigned release_step_p  = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   gate_i,
    adsr_envelope_if.slave         in_if,
    adsr_envelope_if.master        out_if,
    output logic [env_width_p-1:0] env_o
);

    localparam int unsigned ProdW = width_p + env_width_p + 1;
    localparam int unsigned EnvW1 = env_width_p + 1;

    localparam logic [EnvW1-1:0] EnvMax     = {1'b0, {env_width_p{1'b1}}};
    localparam logic [EnvW1-1:0] AttackStep = EnvW1'(attack_step_p);
    localparam logic [EnvW1-1:0] DecayStep  = EnvW1'(decay_step_p);
    localparam logic [EnvW1-1:0] SustainLvl = EnvW1'(sustain_level_p);
    localparam logic [EnvW1-1:0] RelStep    = EnvW1'(release_step_p);

    typedef enum logic [2:0] {StIdle, StAttack, StDecay, StSustain, StRelease} state_e;

    state_e                   state_q, state_d;
    logic [env_width_p-1:0]   env_q, env_d;
    logic                     valid_q, valid_d;
    logic [width_p-1:0]       data_q, data_d;

    logic                     accept;
    logic                     gate_fire;
    logic [EnvW1-1:0]         env_ext;
    logic [EnvW1-1:0]         attack_sum;
    logic signed [width_p-1:0]  din_s;
    logic signed [EnvW1-1:0]    env_s;
    logic signed [ProdW-1:0]    prod;
    logic [width_p-1:0]       scaled;
    logic                     unused_prod;

    assign in_if.ready  = ~valid_q | out_if.ready;
    assign accept       = in_if.valid & in_if.ready;
    assign out_if.valid = valid_q;
    assign out_if.data  = data_q;
    assign env_o        = env_q;

    // Floor scaling: arithmetic shift of the signed product, keep the low width_p bits.
    assign din_s       = $signed(in_if.data);
    assign env_s       = $signed({1'b0, env_q});
    assign prod        = ProdW'(din_s) * ProdW'(env_s);
    assign scaled      = prod[env_width_p +: width_p];
    assign unused_prod = ^{prod[ProdW-1], prod[env_width_p-1:0]};

    assign env_ext    = {1'b0, env_q};
    assign attack_sum = env_ext + AttackStep;

    always_comb begin
        gate_fire = 1'b0;
        unique case (state_q)
            StIdle, StRelease:           gate_fire = gate_i;
            StAttack, StDecay, StSustain: gate_fire = ~gate_i;
            default:                     gate_fire = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (gate_fire) begin
            // Retrigger keeps the current level; release starts from wherever we are.
            state_d = gate_i ? StAttack : StRelease;
        end else if (accept) begin
            unique case (state_q)
                StAttack: begin
                    if (attack_sum >= EnvMax) begin
                        env_d   = EnvMax[env_width_p-1:0];
                        state_d = StDecay;
                    end else begin
                        env_d = attack_sum[env_width_p-1:0];
                    end
                end
                StDecay: begin
                    if (env_ext <= SustainLvl + DecayStep) begin
                        env_d   = SustainLvl[env_width_p-1:0];
                        state_d = StSustain;
                    end else begin
                        env_d = env_q - DecayStep[env_width_p-1:0];
                    end
                end
                StSustain: env_d = SustainLvl[env_width_p-1:0];
                StRelease: begin
                    if (env_ext <= RelStep) begin
                        env_d   = '0;
                        state_d = StIdle;
                    end else begin
                        env_d = env_q - RelStep[env_width_p-1:0];
                    end
                end
                default: env_d = '0;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = scaled;
        end else if (valid_q && out_if.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            env_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a behavioural envelope model.
module tb_adsr_envelope;

    localparam int W      = 12;
    localparam int EW     = 8;
    localparam int EMAX   = 255;
    localparam int ATK    = 64;
    localparam int DEC    = 16;
    localparam int SUS    = 128;
    localparam int REL    = 32;

    logic          clk;
    logic          rst;
    logic          gate;
    logic [EW-1:0] env_o;

    adsr_envelope_if #(.width_p(W)) in_bus ();
    adsr_envelope_if #(.width_p(W)) out_bus ();

    adsr_envelope dut (
        .clk_i   (clk),
        .reset_i (rst),
        .gate_i  (gate),
        .in_if   (in_bus),
        .out_if  (out_bus),
        .env_o   (env_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model
    string m_ph;
    int    m_env;
    bit    m_valid;
    int    m_data;

    function automatic int scale_ref(int d, int e);
        int p;
        p = d * e;
        if (p >= 0) return p / (1 << EW);
        return -((-p + (1 << EW) - 1) / (1 << EW));
    endfunction

    task automatic model_reset();
        m_ph = "idle"; m_env = 0; m_valid = 1'b0; m_data = 0;
    endtask

    task automatic model_step(bit g, bit v, int d, bit r);
        bit acc;
        acc = v && (!m_valid || r);
        if (acc) begin
            m_data  = scale_ref(d, m_env);
            m_valid = 1'b1;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        if (g && (m_ph == "idle" || m_ph == "release")) begin
            m_ph = "attack";
        end else if (!g && (m_ph == "attack" || m_ph == "decay" || m_ph == "sustain")) begin
            m_ph = "release";
        end else if (acc) begin
            if (m_ph == "attack") begin
                if (m_env + ATK >= EMAX) begin m_env = EMAX; m_ph = "decay"; end
                else m_env = m_env + ATK;
            end else if (m_ph == "decay") begin
                if (m_env <= SUS + DEC) begin m_env = SUS; m_ph = "sustain"; end
                else m_env = m_env - DEC;
            end else if (m_ph == "sustain") begin
                m_env = SUS;
            end else if (m_ph == "release") begin
                if (m_env <= REL) begin m_env = 0; m_ph = "idle"; end
                else m_env = m_env - REL;
            end else begin
                m_env = 0;
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dout();
        return int'($signed(out_bus.data));
    endfunction

    // One clock: drive at posedge+1, check ready, advance model, sample at next posedge+1.
    task automatic cycle(bit g, bit v, int d, bit r);
        gate = g; in_bus.valid = v; in_bus.data = W'(d); out_bus.ready = r;
        #1;
        check("ready_o", int'(in_bus.ready), int'(!m_valid || r));
        model_step(g, v, d, r);
        @(posedge clk);
        #1;
        check("valid_o", int'(out_bus.valid), int'(m_valid));
        check("env_o", int'(env_o), m_env);
        if (m_valid) check("data_o", dout(), m_data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        gate = 1'b0; in_bus.valid = 1'b0; in_bus.data = '0; out_bus.ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit g; bit v; int d; bit r;
        int exp_data; int exp_env;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit g, int d, int ed, int ee);
        vec_t x;
        x.g = g; x.v = 1'b1; x.d = d; x.r = 1'b1; x.exp_data = ed; x.exp_env = ee;
        return x;
    endfunction

    initial begin
        // Attack -> decay -> sustain, negative floor, release to idle
        vecs.push_back(mk(1, 2047, 0, 0));
        vecs.push_back(mk(1, 2047, 0, 64));
        vecs.push_back(mk(1, 2047, 511, 128));
        vecs.push_back(mk(1, 2047, 1023, 192));
        vecs.push_back(mk(1, 2047, 1535, 255));
        vecs.push_back(mk(1, 2047, 2039, 239));
        vecs.push_back(mk(1, 2047, 1911, 223));
        vecs.push_back(mk(1, 2047, 1783, 207));
        vecs.push_back(mk(1, 2047, 1655, 191));
        vecs.push_back(mk(1, 2047, 1527, 175));
        vecs.push_back(mk(1, 2047, 1399, 159));
        vecs.push_back(mk(1, 2047, 1271, 143));
        vecs.push_back(mk(1, 2047, 1143, 128));
        vecs.push_back(mk(1, 2047, 1023, 128));
        vecs.push_back(mk(1, -2047, -1024, 128));
        vecs.push_back(mk(1, -1, -1, 128));
        vecs.push_back(mk(0, 2047, 1023, 128));
        vecs.push_back(mk(0, 2047, 1023, 96));
        vecs.push_back(mk(0, 2047, 767, 64));
        vecs.push_back(mk(0, 2047, 511, 32));
        vecs.push_back(mk(0, 2047, 255, 0));
        vecs.push_back(mk(0, 2047, 0, 0));
        vecs.push_back(mk(0, -2048, 0, 0));

        // Reset state
        rst = 1'b1;
        gate = 1'b0; in_bus.valid = 1'b0; in_bus.data = '0; out_bus.ready = 1'b0;
        model_reset();
        #3;
        check("reset_valid_o", int'(out_bus.valid), 0);
        check("reset_data_o", dout(), 0);
        check("reset_env_o", int'(env_o), 0);
        do_reset();

        foreach (vecs[i]) begin
            cycle(vecs[i].g, vecs[i].v, vecs[i].d, vecs[i].r);
            check($sformatf("vec%0d_data", i), dout(), vecs[i].exp_data);
            check($sformatf("vec%0d_env", i), int'(env_o), vecs[i].exp_env);
            check($sformatf("vec%0d_valid", i), int'(out_bus.valid), 1);
        end

        // Backpressure in ATTACK: output and level freeze, nothing lost or duplicated
        do_reset();
        cycle(1, 1, 2047, 1);
        cycle(1, 1, 2047, 1);
        cycle(1, 1, 2047, 1);
        for (int k = 0; k < 5; k++) begin
            cycle(1, 1, 1000, 0);
            check("bp_ready_o", int'(in_bus.ready), 0);
            check("bp_data_hold", dout(), 511);
            check("bp_env_hold", int'(env_o), 128);
        end
        cycle(1, 1, 1000, 1);
        check("bp_resume_data", dout(), 500);
        check("bp_resume_env", int'(env_o), 192);
        cycle(1, 1, 1000, 1);
        check("bp_next_data", dout(), 750);

        // Asynchronous reset mid-ATTACK with an output pending
        do_reset();
        cycle(1, 1, 2047, 1);
        cycle(1, 1, 2047, 1);
        cycle(1, 1, 2047, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_valid_o", int'(out_bus.valid), 0);
        check("arst_data_o", dout(), 0);
        check("arst_env_o", int'(env_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(0, 1, 2047, 1);
        check("post_reset_idle_data", dout(), 0);

        // Retrigger from RELEASE at env=64 keeps the level
        do_reset();
        for (int k = 0; k < 15; k++) cycle(1, 1, 2047, 1);
        check("rt_sustain_env", int'(env_o), 128);
        cycle(0, 1, 2047, 1);
        cycle(0, 1, 2047, 1);
        cycle(0, 1, 2047, 1);
        check("rt_release_env", int'(env_o), 64);
        cycle(1, 1, 2047, 1);
        check("rt_trigger_env", int'(env_o), 64);
        cycle(1, 1, 2047, 1);
        check("rt_env_128", int'(env_o), 128);
        cycle(1, 1, 2047, 1);
        check("rt_env_192", int'(env_o), 192);
        cycle(1, 1, 2047, 1);
        check("rt_env_255", int'(env_o), 255);

        // Randomized traffic against the model
        do_reset();
        begin
            bit g;
            g = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(29) == 0) g = ~g;
                cycle(g, $urandom_range(3) != 0, int'($urandom_range(4095)) - 2048,
                      $urandom_range(3) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
